usb_spi_responder: RTL and testbench

- SPI mode-0 responder that emulates the MAX3421E-style register interface seen by the SoC's spi0 master (spi0_SCLK/MOSI/SS_n out, spi0_MISO in).
- Holds a 32x8 register file. The SPI side reads and writes it; a fabric-side host port lets game/test logic preload and observe registers.
- Drives an interrupt pin toward usb_irq_export.
- Used for simulation and board bring-up of the USB driver without a physical USB chip.

---
 rtl/usb_spi_responder_if.sv | 27 ++
 rtl/usb_spi_responder.sv | 191 +++++++++++++++++++
 tb/tb_usb_spi_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_spi_responder_if.sv
// Pin bundle of the USB/SPI responder: SPI wires toward the SoC master
// plus the fabric-side host register port and status outputs.
interface usb_spi_responder_if;
    logic       spi_sclk;
    logic       spi_ss_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [4:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_we;
    logic [7:0] host_rdata;
    logic       usb_int;
    logic       xfer_done;

    modport master (
        output spi_sclk, spi_ss_n, spi_mosi,
        output host_addr, host_wdata, host_we,
        input  spi_miso, spi_miso_oe, host_rdata, usb_int, xfer_done
    );

    modport slave (
        input  spi_sclk, spi_ss_n, spi_mosi,
        input  host_addr, host_wdata, host_we,
        output spi_miso, spi_miso_oe, host_rdata, usb_int, xfer_done
    );
endinterface

// File: rtl/usb_spi_responder.sv
// SPI mode-0 responder emulating a MAX3421E-style 32x8 register file,
// with a host port for preload/observe and an interrupt output.
module usb_spi_responder #(
    parameter int SYNC_STAGES    = 2,
    parameter int HIRQ_ADDR      = 25,
    parameter int HIEN_ADDR      = 26,
    parameter bit INT_ACTIVE_LOW = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    usb_spi_responder_if.slave bus
);

    localparam logic [4:0] HIRQ = 5'(HIRQ_ADDR);
    localparam logic [4:0] HIEN = 5'(HIEN_ADDR);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             rx_q, rx_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [4:0]             addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic                   skip_q, skip_d;
    logic                   cmd_done_q, cmd_done_d;
    logic [7:0]             regs_q [32];
    logic [7:0]             regs_d [32];
    logic [7:0]             rdata_q, rdata_d;
    logic                   int_q, int_d;
    logic                   done_q, done_d;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic       spi_we;
    logic [7:0] rx_next;

    assign bus.spi_miso_oe = (state_q != IDLE);
    assign bus.spi_miso    = (state_q != IDLE) & tx_q[7];
    assign bus.host_rdata  = rdata_q;
    assign bus.usb_int     = int_q;
    assign bus.xfer_done   = done_q;

    // Next-state logic: synchronizers, SPI byte engine, regfile writes.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        ss_fall     = ~ss_s & ss_prev_q;
        ss_rise     = ss_s & ~ss_prev_q;
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        rx_next     = {rx_q[6:0], mosi_s};

        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        skip_d     = skip_q;
        cmd_done_d = cmd_done_q;
        done_d     = 1'b0;
        spi_we     = 1'b0;
        regs_d     = regs_q;

        if (bus.host_we) begin
            if (bus.host_addr == HIRQ)
                regs_d[HIRQ] = regs_q[HIRQ] | bus.host_wdata;
            else
                regs_d[bus.host_addr] = bus.host_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d       = regs_q[HIRQ];
                    rx_d       = '0;
                    cnt_d      = '0;
                    skip_d     = 1'b0;
                    cmd_done_d = 1'b0;
                    state_d    = CMD;
                end
            end
            CMD, DATA: begin
                if (ss_rise) begin
                    state_d    = IDLE;
                    tx_d       = '0;
                    rx_d       = '0;
                    cnt_d      = '0;
                    skip_d     = 1'b0;
                    done_d     = cmd_done_q;
                    cmd_done_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (state_q == CMD) begin
                            addr_d     = rx_next[7:3];
                            wr_d       = rx_next[1];
                            cmd_done_d = 1'b1;
                            state_d    = DATA;
                            if (!rx_next[1]) begin
                                tx_d   = regs_q[rx_next[7:3]];
                                skip_d = 1'b1;
                            end
                        end else if (wr_q) begin
                            spi_we = 1'b1;
                        end else begin
                            tx_d   = regs_q[addr_q];
                            skip_d = 1'b1;
                        end
                    end
                end else if (sclk_fall) begin
                    // A freshly preloaded byte must survive the fall
                    // that closes the byte it was loaded in.
                    if (skip_q)
                        skip_d = 1'b0;
                    else
                        tx_d = {tx_q[6:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // SPI commit is applied after the host write so it wins.
        if (spi_we) begin
            if (addr_q == HIRQ)
                regs_d[HIRQ] = regs_d[HIRQ] & ~rx_next;
            else
                regs_d[addr_q] = rx_next;
        end

        rdata_d = regs_d[bus.host_addr];
        int_d   = ((regs_d[HIRQ] & regs_d[HIEN]) != 8'h00) ^ INT_ACTIVE_LOW;
    end

    // State registers; SS_n sync starts low so a select already active
    // at reset release is not taken as a new falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            skip_q      <= 1'b0;
            cmd_done_q  <= 1'b0;
            for (int i = 0; i < 32; i++)
                regs_q[i] <= '0;
            rdata_q     <= '0;
            int_q       <= INT_ACTIVE_LOW;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            skip_q      <= skip_d;
            cmd_done_q  <= cmd_done_d;
            regs_q      <= regs_d;
            rdata_q     <= rdata_d;
            int_q       <= int_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_usb_spi_responder.sv
// Self-checking bench for usb_spi_responder: directed scenarios plus
// randomized SPI/host traffic against a transaction-level register model.
module tb_usb_spi_responder;

    localparam int         H    = 8;
    localparam logic [4:0] HIRQ = 5'd25;
    localparam logic [4:0] HIEN = 5'd26;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_spi_responder_if bus();

    usb_spi_responder #(
        .SYNC_STAGES(2),
        .HIRQ_ADDR(25),
        .HIEN_ADDR(26),
        .INT_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] m_regs [32];
    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_chg = 0;
    int done_cnt = 0;
    int exp_done = 0;
    bit run_chk  = 1'b0;
    bit exp_sel  = 1'b0;

    bit         t_cmd_done;
    logic [4:0] t_addr;
    bit         t_wr;
    logic [7:0] t_exp;

    bit         coll_en;
    logic [4:0] coll_addr;
    logic [7:0] coll_data;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic exp_int();
        return ((m_regs[HIRQ] & m_regs[HIEN]) != 8'h00) ? 1'b0 : 1'b1;
    endfunction

    function automatic void m_host_wr(input logic [4:0] a, input logic [7:0] d);
        if (a == HIRQ) m_regs[a] = m_regs[a] | d;
        else m_regs[a] = d;
    endfunction

    function automatic void m_spi_wr(input logic [4:0] a, input logic [7:0] d);
        if (a == HIRQ) m_regs[a] = m_regs[a] & ~d;
        else m_regs[a] = d;
    endfunction

    task automatic mark();
        last_chg = cyc;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Continuous comparison of register-derived outputs once settled.
    always @(negedge clk) begin
        cyc++;
        if (!rst && bus.xfer_done) done_cnt++;
        if (!rst && run_chk && (cyc - last_chg > 6)) begin
            check("usb_int", bus.usb_int, exp_int());
            check("miso_oe", bus.spi_miso_oe, exp_sel);
            check("host_rdata", bus.host_rdata, m_regs[bus.host_addr]);
            if (!exp_sel) check("miso_idle", bus.spi_miso, 0);
        end
    end

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_we    = 1'b1;
        m_host_wr(a, d);
        mark();
        @(negedge clk);
        bus.host_we = 1'b0;
        mark();
    endtask

    task automatic host_read(input string name, input logic [4:0] a,
                             input logic [7:0] exp);
        @(negedge clk);
        bus.host_addr = a;
        mark();
        @(negedge clk);
        check(name, bus.host_rdata, exp);
    endtask

    task automatic byte_end(input logic [7:0] d);
        if (!t_cmd_done) begin
            t_cmd_done = 1'b1;
            t_addr     = d[7:3];
            t_wr       = d[1];
            t_exp      = d[1] ? 8'h00 : m_regs[d[7:3]];
        end else if (t_wr) begin
            m_spi_wr(t_addr, d);
            t_exp = 8'h00;
        end else begin
            t_exp = m_regs[t_addr];
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        bus.spi_ss_n = 1'b0;
        mark();
        exp_sel    = 1'b1;
        t_cmd_done = 1'b0;
        t_exp      = m_regs[HIRQ];
        wait_clk(H);
    endtask

    task automatic spi_end();
        @(negedge clk);
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        mark();
        exp_sel = 1'b0;
        if (t_cmd_done) exp_done++;
        t_cmd_done = 1'b0;
        wait_clk(H);
        check("xfer_done_count", done_cnt, exp_done);
    endtask

    task automatic spi_byte(input logic [7:0] d, input int nbits,
                            output logic [7:0] m);
        logic [7:0] exp_b;
        exp_b = t_exp;
        m     = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.spi_mosi = d[7-i];
            mark();
            wait_clk(H);
            m = {m[6:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            mark();
            if (i == 7) begin
                if (coll_en) m_host_wr(coll_addr, coll_data);
                byte_end(d);
            end
            if (i == 7 && coll_en) begin
                wait_clk(2);
                bus.host_addr  = coll_addr;
                bus.host_wdata = coll_data;
                bus.host_we    = 1'b1;
                mark();
                @(negedge clk);
                bus.host_we = 1'b0;
                coll_en     = 1'b0;
                wait_clk(H - 3);
            end else begin
                wait_clk(H);
            end
            bus.spi_sclk = 1'b0;
            mark();
        end
        if (nbits == 8) check("miso_byte", m, exp_b);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        int         d0;
        bus.spi_sclk   = 1'b0;
        bus.spi_ss_n   = 1'b1;
        bus.spi_mosi   = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.host_we    = 1'b0;
        coll_en        = 1'b0;
        coll_addr      = '0;
        coll_data      = '0;
        t_cmd_done     = 1'b0;
        t_addr         = '0;
        t_wr           = 1'b0;
        t_exp          = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;

        rst = 1'b1;
        wait_clk(5);
        check("rst_miso", bus.spi_miso, 0);
        check("rst_miso_oe", bus.spi_miso_oe, 0);
        check("rst_rdata", bus.host_rdata, 0);
        check("rst_done", bus.xfer_done, 0);
        check("rst_int", bus.usb_int, 1);
        @(negedge clk);
        rst = 1'b0;
        mark();
        run_chk = 1'b1;
        wait_clk(4);

        // SPI write of 0x5A to reg1
        host_write(HIRQ, 8'h00);
        spi_begin();
        spi_byte(8'h0A, 8, m);
        check("wr_cmd_miso", m, 8'h00);
        spi_byte(8'h5A, 8, m);
        spi_end();
        host_read("wr_reg1", 5'd1, 8'h5A);

        // SPI read of reg3
        host_write(5'd3, 8'hC3);
        d0 = done_cnt;
        spi_begin();
        spi_byte(8'h18, 8, m);
        check("rd_status", m, 8'h00);
        spi_byte(8'h00, 8, m);
        check("rd_data", m, 8'hC3);
        spi_end();
        check("rd_done_once", done_cnt - d0, 1);

        // Interrupt raise by host, clear by SPI W1C
        host_write(HIEN, 8'h04);
        host_write(HIRQ, 8'h04);
        wait_clk(8);
        check("int_asserted", bus.usb_int, 0);
        spi_begin();
        spi_byte(8'hCA, 8, m);
        check("int_status", m, 8'h04);
        spi_byte(8'h04, 8, m);
        spi_end();
        wait_clk(8);
        check("int_cleared", bus.usb_int, 1);
        host_read("hirq_zero", HIRQ, 8'h00);
        spi_begin();
        spi_byte(8'h18, 8, m);
        check("status_after_clr", m, 8'h00);
        spi_byte(8'h00, 8, m);
        spi_end();

        // Abort a write after 5 data bits
        host_write(5'd2, 8'h11);
        spi_begin();
        spi_byte(8'h12, 8, m);
        spi_byte(8'hFF, 5, m);
        spi_end();
        host_read("abort_reg2", 5'd2, 8'h11);
        spi_begin();
        spi_byte(8'h10, 8, m);
        spi_byte(8'h00, 8, m);
        check("abort_next_rd", m, 8'h11);
        spi_end();

        // Same-cycle host and SPI writes
        spi_begin();
        spi_byte(8'h3A, 8, m);
        coll_en   = 1'b1;
        coll_addr = 5'd7;
        coll_data = 8'hAA;
        spi_byte(8'h55, 8, m);
        spi_end();
        host_read("coll_reg7", 5'd7, 8'h55);
        host_write(HIRQ, 8'h01);
        spi_begin();
        spi_byte(8'hCA, 8, m);
        coll_en   = 1'b1;
        coll_addr = HIRQ;
        coll_data = 8'h06;
        spi_byte(8'h02, 8, m);
        spi_end();
        host_read("coll_hirq", HIRQ, 8'h05);

        // Reset in the middle of a read data byte
        host_write(5'd4, 8'h77);
        spi_begin();
        spi_byte(8'h20, 8, m);
        spi_byte(8'h00, 3, m);
        @(negedge clk);
        rst = 1'b1;
        mark();
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        exp_sel    = 1'b0;
        t_cmd_done = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        mark();
        wait_clk(8);
        check("mrst_miso_oe", bus.spi_miso_oe, 0);
        check("mrst_int", bus.usb_int, 1);
        host_read("mrst_reg4", 5'd4, 8'h00);
        host_read("mrst_reg7", 5'd7, 8'h00);
        spi_end();
        host_write(5'd4, 8'h3C);
        spi_begin();
        spi_byte(8'h20, 8, m);
        spi_byte(8'h00, 8, m);
        check("mrst_next_rd", m, 8'h3C);
        spi_end();

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int         op;
            logic [4:0] a;
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: a = HIRQ;
                1: a = HIEN;
                default: a = 5'($urandom_range(0, 31));
            endcase
            if (op == 0) begin
                host_write(a, 8'($urandom));
            end else if (op == 1) begin
                host_read("rand_read", a, m_regs[a]);
            end else begin
                logic [7:0] cmd;
                int         nb;
                bit         abort;
                cmd   = {a, 1'($urandom), 1'($urandom), 1'($urandom)};
                nb    = $urandom_range(0, 3);
                abort = ($urandom_range(0, 4) == 0);
                spi_begin();
                if (abort && nb == 0) begin
                    spi_byte(cmd, $urandom_range(1, 7), m);
                end else begin
                    spi_byte(cmd, 8, m);
                    for (int b = 0; b < nb; b++) begin
                        int nbits;
                        nbits = (abort && b == nb - 1) ? $urandom_range(1, 7) : 8;
                        spi_byte(8'($urandom), nbits, m);
                    end
                end
                spi_end();
            end
        end

        wait_clk(10);
        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
